// File: rtl/uart_cam_responder.sv
// Single-byte command responder: 'S' dumps a camera FIFO frame, '?' reports status, anything else is NAKed.
// Define UART_CAM_CKSUM_EN to append a modulo-256 data checksum after the last data byte of a dump.
module uart_cam_responder #(
    parameter logic [15:0] frame_len = 16'd1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_avail,
    input  logic       rx_error,
    output logic       rx_ack,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_busy,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic       busy
);

    localparam logic [7:0] CMD_DUMP  = 8'h53;
    localparam logic [7:0] CMD_STAT  = 8'h3F;
    localparam logic [7:0] CMD_ABORT = 8'h58;
    localparam logic [7:0] BYTE_NAK  = 8'h15;
    localparam logic [7:0] BYTE_HDR  = 8'hA5;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DECODE    = 4'd1,
        SEND_HDR  = 4'd2,
        FETCH     = 4'd3,
        LOAD      = 4'd4,
        SEND_DATA = 4'd5,
`ifdef UART_CAM_CKSUM_EN
        SEND_CKS  = 4'd6,
`endif
        SEND_STAT = 4'd7,
        TX_HOLD   = 4'd8,
        TX_WAIT   = 4'd9
    } state_t;

`ifdef UART_CAM_CKSUM_EN
    localparam state_t FRAME_END = SEND_CKS;
`else
    localparam state_t FRAME_END = IDLE;
`endif

    state_t      state, state_n;
    state_t      ret_state, ret_state_n;
    logic [7:0]  cmd, cmd_n;
    logic        cmd_err, cmd_err_n;
    logic        err_sticky, err_sticky_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] cnt_inc;
    logic        ack_dly;
    logic        rx_ok;
    logic        rx_ack_n, tx_wr_n, fifo_rd_n, busy_n;
    logic [7:0]  tx_data_n;
`ifdef UART_CAM_CKSUM_EN
    logic [7:0]  cks, cks_n;
`endif

    // A byte still pending in the cycle of the ack or just after it is the one already taken.
    assign rx_ok   = rx_avail & ~rx_ack & ~ack_dly;
    assign cnt_inc = cnt + 16'd1;

    // Next-state and next-output logic for the responder FSM.
    always_comb begin
        state_n      = state;
        ret_state_n  = ret_state;
        cmd_n        = cmd;
        cmd_err_n    = cmd_err;
        err_sticky_n = err_sticky;
        cnt_n        = cnt;
        tx_data_n    = tx_data;
        busy_n       = busy;
        rx_ack_n     = 1'b0;
        tx_wr_n      = 1'b0;
        fifo_rd_n    = 1'b0;
`ifdef UART_CAM_CKSUM_EN
        cks_n        = cks;
`endif
        case (state)
            IDLE: begin
                if (rx_ok) begin
                    rx_ack_n  = 1'b1;
                    cmd_n     = rx_data;
                    cmd_err_n = rx_error;
                    state_n   = DECODE;
                end else begin
                    state_n = IDLE;
                end
            end
            DECODE: begin
                if (cmd_err) begin
                    err_sticky_n = 1'b1;
                    state_n      = IDLE;
                end else if (cmd == CMD_DUMP) begin
                    busy_n  = 1'b1;
                    state_n = SEND_HDR;
                end else if (cmd == CMD_STAT) begin
                    // Status is frozen here so the reply reflects the moment of entry.
                    tx_data_n = {6'b000000, err_sticky, fifo_empty};
                    state_n   = SEND_STAT;
                end else if (!tx_busy) begin
                    tx_wr_n     = 1'b1;
                    tx_data_n   = BYTE_NAK;
                    ret_state_n = IDLE;
                    state_n     = TX_HOLD;
                end else begin
                    state_n = DECODE;
                end
            end
            SEND_HDR: begin
                if (!tx_busy) begin
                    tx_wr_n     = 1'b1;
                    tx_data_n   = BYTE_HDR;
                    ret_state_n = FETCH;
                    state_n     = TX_HOLD;
                end else begin
                    state_n = SEND_HDR;
                end
            end
            FETCH: begin
                if (rx_ok && !rx_error && rx_data == CMD_ABORT) begin
                    rx_ack_n = 1'b1;
                    busy_n   = 1'b0;
                    cnt_n    = 16'd0;
`ifdef UART_CAM_CKSUM_EN
                    cks_n    = 8'h00;
`endif
                    state_n  = IDLE;
                end else begin
                    if (rx_ok) begin
                        rx_ack_n = 1'b1;
                        if (rx_error) begin
                            err_sticky_n = 1'b1;
                        end else begin
                            err_sticky_n = err_sticky;
                        end
                    end else begin
                        rx_ack_n = 1'b0;
                    end
                    if (!fifo_empty) begin
                        fifo_rd_n = 1'b1;
                        state_n   = LOAD;
                    end else begin
                        state_n = FETCH;
                    end
                end
            end
            LOAD: begin
                // fifo_rd is registered, so read data arrives one cycle after the pulse is seen here.
                if (fifo_rd) begin
                    state_n = LOAD;
                end else begin
                    tx_data_n = fifo_data;
`ifdef UART_CAM_CKSUM_EN
                    cks_n     = cks + fifo_data;
`endif
                    state_n   = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (!tx_busy) begin
                    tx_wr_n = 1'b1;
                    cnt_n   = cnt_inc;
                    if (cnt_inc == frame_len) begin
                        ret_state_n = FRAME_END;
                    end else begin
                        ret_state_n = FETCH;
                    end
                    state_n = TX_HOLD;
                end else begin
                    state_n = SEND_DATA;
                end
            end
`ifdef UART_CAM_CKSUM_EN
            SEND_CKS: begin
                if (!tx_busy) begin
                    tx_wr_n     = 1'b1;
                    tx_data_n   = cks;
                    ret_state_n = IDLE;
                    state_n     = TX_HOLD;
                end else begin
                    state_n = SEND_CKS;
                end
            end
`endif
            SEND_STAT: begin
                if (!tx_busy) begin
                    tx_wr_n      = 1'b1;
                    err_sticky_n = 1'b0;
                    ret_state_n  = IDLE;
                    state_n      = TX_HOLD;
                end else begin
                    state_n = SEND_STAT;
                end
            end
            TX_HOLD: begin
                state_n = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    state_n = ret_state;
                    if (ret_state == IDLE) begin
                        busy_n = 1'b0;
                        cnt_n  = 16'd0;
`ifdef UART_CAM_CKSUM_EN
                        cks_n  = 8'h00;
`endif
                    end else begin
                        busy_n = busy;
                    end
                end else begin
                    state_n = TX_WAIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, context and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ret_state  <= IDLE;
            cmd        <= 8'h00;
            cmd_err    <= 1'b0;
            err_sticky <= 1'b0;
            cnt        <= 16'd0;
            ack_dly    <= 1'b0;
            rx_ack     <= 1'b0;
            tx_wr      <= 1'b0;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            tx_data    <= 8'h00;
`ifdef UART_CAM_CKSUM_EN
            cks        <= 8'h00;
`endif
        end else begin
            state      <= state_n;
            ret_state  <= ret_state_n;
            cmd        <= cmd_n;
            cmd_err    <= cmd_err_n;
            err_sticky <= err_sticky_n;
            cnt        <= cnt_n;
            ack_dly    <= rx_ack;
            rx_ack     <= rx_ack_n;
            tx_wr      <= tx_wr_n;
            fifo_rd    <= fifo_rd_n;
            busy       <= busy_n;
            tx_data    <= tx_data_n;
`ifdef UART_CAM_CKSUM_EN
            cks        <= cks_n;
`endif
        end
    end

endmodule
